// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: load/store sequencing against a word-addressed data bus
// with lane steering, sign extension, misalignment flagging and ack timeout.
module rv32i_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] pc_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_reg_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] wb_data_out,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic        wb_en_out,
    output logic [4:0]  wb_reg_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        is_load, is_store, mem_op, op_valid, misaligned, accept;
    logic [2:0]  funct3;

    logic [31:0] hold_addr, hold_rs2, hold_iw, hold_pc;
    logic        hold_wb_en;
    logic [4:0]  hold_wb_reg;
    logic [7:0]  cnt;
    logic        hold_store, timeout;
    logic [2:0]  hold_f3;

    logic [3:0]  lane_be;
    logic [31:0] store_data, load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    logic [31:0] n_data, n_iw, n_pc;
    logic [4:0]  n_reg;
    logic        n_en, n_mis, n_err;

    always_comb begin
        funct3   = iw_in[14:12];
        is_load  = (iw_in[6:0] == OP_LOAD);
        is_store = (iw_in[6:0] == OP_STORE);
        mem_op   = is_load || is_store;
        op_valid = 1'b0;
        if (is_load)
            op_valid = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_store)
            op_valid = funct3 inside {3'b000, 3'b001, 3'b010};
        misaligned = ((funct3[1:0] == 2'b01) && alu_in[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00));
        accept = (state == IDLE) && mem_op && op_valid && !misaligned;
    end

    // Opcode bit 5 separates STORE (0100011) from LOAD (0000011) once captured.
    assign hold_store = hold_iw[5];
    assign hold_f3    = hold_iw[14:12];
    assign timeout    = (state == ACCESS) && !dmem_ack && (cnt == LAST_CYCLE);

    always_comb begin
        lane_be    = 4'b1111;
        store_data = hold_rs2;
        case (hold_f3[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << hold_addr[1:0];
                store_data = {4{hold_rs2[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << hold_addr[1:0];
                store_data = {2{hold_rs2[15:0]}};
            end
            default: ;
        endcase

        case (hold_addr[1:0])
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = hold_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (hold_f3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        stall_out  = (state == ACCESS);
        dmem_req   = (state == ACCESS);
        dmem_we    = (state == ACCESS) && hold_store;
        dmem_addr  = (state == ACCESS) ? {hold_addr[31:2], 2'b00} : '0;
        dmem_be    = (state == ACCESS) ? lane_be : '0;
        dmem_wdata = ((state == ACCESS) && hold_store) ? store_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  if (dmem_ack || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        n_data = wb_data_out;
        n_iw   = iw_out;
        n_pc   = pc_out;
        n_reg  = wb_reg_out;
        n_en   = 1'b0;
        n_mis  = 1'b0;
        n_err  = 1'b0;
        if (state == IDLE) begin
            n_data = alu_in;
            n_iw   = iw_in;
            n_pc   = pc_in;
            n_reg  = wb_reg_in;
            if (!mem_op)
                n_en = wb_en_in;
            else if (op_valid && misaligned)
                n_mis = 1'b1;
        end else if (dmem_ack || timeout) begin
            n_iw   = hold_iw;
            n_pc   = hold_pc;
            n_reg  = hold_wb_reg;
            n_data = (hold_store || timeout) ? hold_addr : load_data;
            n_en   = dmem_ack && !hold_store && hold_wb_en;
            n_err  = !dmem_ack;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_data_out  <= '0;
            iw_out       <= '0;
            pc_out       <= '0;
            wb_reg_out   <= '0;
            wb_en_out    <= 1'b0;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
            hold_addr    <= '0;
            hold_rs2     <= '0;
            hold_iw      <= '0;
            hold_pc      <= '0;
            hold_wb_en   <= 1'b0;
            hold_wb_reg  <= '0;
            cnt          <= '0;
        end else begin
            wb_data_out  <= n_data;
            iw_out       <= n_iw;
            pc_out       <= n_pc;
            wb_reg_out   <= n_reg;
            wb_en_out    <= n_en;
            misalign_out <= n_mis;
            bus_err_out  <= n_err;
            if (accept) begin
                hold_addr   <= alu_in;
                hold_rs2    <= rs2_data_in;
                hold_iw     <= iw_in;
                hold_pc     <= pc_in;
                hold_wb_en  <= wb_en_in;
                hold_wb_reg <= wb_reg_in;
                cnt         <= '0;
            end else if (state == ACCESS && !dmem_ack && !timeout) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Bench for rv32i_mem_stage: directed vector table, reset corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_rv32i_mem_stage;

    localparam int TO    = 4;
    localparam int K_PAS = 0;
    localparam int K_INV = 1;
    localparam int K_MIS = 2;
    localparam int K_ACC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_in, rs2_data_in, iw_in, pc_in;
    logic        wb_en_in;
    logic [4:0]  wb_reg_in;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] wb_data_out, iw_out, pc_out;
    logic        wb_en_out, misalign_out, bus_err_out;
    logic [4:0]  wb_reg_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          kind;
        logic [31:0] iw, alu, rs2, rdata;
        int          ack_at;
        logic        wb_en;
        logic [31:0] e_data;
        logic        e_en, e_err;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } op_t;

    op_t tbl[16];

    rv32i_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .alu_in(alu_in), .rs2_data_in(rs2_data_in), .iw_in(iw_in), .pc_in(pc_in),
        .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_data_out(wb_data_out), .iw_out(iw_out), .pc_out(pc_out), .wb_en_out(wb_en_out),
        .wb_reg_out(wb_reg_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: expectations from the instruction rules using plain arithmetic.
    function automatic op_t model(logic [31:0] iw, logic [31:0] alu, logic [31:0] rs2,
                                  logic [31:0] rdata, int ack_at, logic wb_en);
        op_t v;
        int unsigned opc, f3, nb, off;
        longint unsigned val, full;
        v = '{default: 0};
        v.iw = iw; v.alu = alu; v.rs2 = rs2; v.rdata = rdata; v.ack_at = ack_at; v.wb_en = wb_en;
        opc = iw % 128;
        f3  = (iw / 4096) % 8;
        off = alu % 4;
        nb  = 1 << (f3 % 4);
        if (opc != 3 && opc != 35) begin
            v.kind = K_PAS; v.e_data = alu; v.e_en = wb_en;
            return v;
        end
        if ((opc == 3 && (f3 == 3 || f3 >= 6)) || (opc == 35 && f3 >= 3)) begin
            v.kind = K_INV;
            return v;
        end
        if (alu % nb != 0) begin
            v.kind = K_MIS;
            return v;
        end
        v.kind   = K_ACC;
        v.e_addr = alu - off;
        v.e_we   = (opc == 35);
        v.e_be   = 4'(((1 << nb) - 1) << off);
        if (nb == 1)      v.e_wdata = (rs2 % 256) * 32'h0101_0101;
        else if (nb == 2) v.e_wdata = (rs2 % 65536) * 32'h0001_0001;
        else              v.e_wdata = rs2;
        if (ack_at == 0) begin
            v.e_err = 1'b1;
            return v;
        end
        if (v.e_we) begin
            v.e_data = alu;
        end else begin
            full = 64'd1 << (8 * nb);
            val  = (64'(rdata) >> (8 * off)) % full;
            if (f3 < 4 && nb < 4 && val >= full / 2)
                val = val + 64'h1_0000_0000 - full;
            v.e_data = 32'(val);
            v.e_en   = wb_en;
        end
        return v;
    endfunction

    task automatic run_op(input op_t v, input logic [31:0] pc, input logic [4:0] reg_no);
        int cyc;
        int exp_cyc;
        iw_in = v.iw; alu_in = v.alu; rs2_data_in = v.rs2; pc_in = pc;
        wb_en_in = v.wb_en; wb_reg_in = reg_no;
        dmem_ack = 1'($urandom % 2);
        dmem_rdata = $urandom;
        @(negedge clk);
        dmem_ack = 1'b0;
        cyc = 0;
        exp_cyc = (v.ack_at == 0) ? TO : v.ack_at;
        if (v.kind == K_ACC) begin
            check("accept_bubble", 64'({stall_out, wb_en_out, misalign_out, bus_err_out}), 64'(4'b1000));
            while (stall_out && cyc < TO + 2) begin
                cyc++;
                check("access_bus", 64'({dmem_req, dmem_we, dmem_be, dmem_addr}),
                      64'({1'b1, v.e_we, v.e_be, v.e_addr}));
                if (v.e_we) check("store_wdata", 64'(dmem_wdata), 64'(v.e_wdata));
                if (cyc > 1) check("wait_bubble", 64'({wb_en_out, misalign_out, bus_err_out}), 64'(0));
                iw_in = $urandom; alu_in = $urandom; rs2_data_in = $urandom; pc_in = $urandom;
                wb_en_in = 1'b1; wb_reg_in = 5'($urandom);
                dmem_ack = (cyc == v.ack_at);
                dmem_rdata = dmem_ack ? v.rdata : $urandom;
                @(negedge clk);
                dmem_ack = 1'b0;
            end
            check("req_cycles", 64'(cyc), 64'(exp_cyc));
        end
        check("idle_after", 64'({stall_out, dmem_req}), 64'(0));
        check("wb_en", 64'(wb_en_out), 64'(v.e_en));
        check("misalign", 64'(misalign_out), 64'(v.kind == K_MIS));
        check("bus_err", 64'(bus_err_out), 64'(v.e_err));
        if (v.kind != K_INV)
            check("tag", {iw_out, pc_out}, {v.iw, pc});
        if (v.kind != K_INV)
            check("wb_reg", 64'(wb_reg_out), 64'(reg_no));
        if (v.kind == K_PAS || (v.kind == K_ACC && !v.e_err))
            check("wb_data", 64'(wb_data_out), 64'(v.e_data));
        iw_in = 32'h0000_0013;
        wb_en_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus"}, 64'({stall_out, dmem_req, dmem_we, dmem_be}), 64'(0));
        check({tag, "_bus_data"}, {dmem_addr, dmem_wdata}, 64'(0));
        check({tag, "_wb"}, {wb_data_out, iw_out}, 64'(0));
        check({tag, "_wb_ctl"}, 64'({pc_out, wb_en_out, wb_reg_out, misalign_out, bus_err_out}), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{K_PAS, 32'h0000_0033, 32'h5, 0, 0, 0, 1'b1, 32'h5, 1'b1, 1'b0, 0, 1'b0, 4'h0, 0};
        tbl[1]  = '{K_ACC, 32'h0000_0023, 32'h1003, 32'hAABB_CCDD, 0, 1, 1'b1, 32'h1003, 1'b0, 1'b0, 32'h1000, 1'b1, 4'b1000, 32'hDDDD_DDDD};
        tbl[2]  = '{K_ACC, 32'h0000_0003, 32'h2002, 0, 32'h0080_0000, 3, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 32'h2000, 1'b0, 4'b0100, 0};
        tbl[3]  = '{K_ACC, 32'h0000_4003, 32'h2002, 0, 32'h0080_0000, 3, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h2000, 1'b0, 4'b0100, 0};
        tbl[4]  = '{K_MIS, 32'h0000_2003, 32'h2001, 0, 0, 0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 4'h0, 0};
        tbl[5]  = '{K_ACC, 32'h0000_1023, 32'h2002, 32'h1234_5678, 0, 1, 1'b1, 32'h2002, 1'b0, 1'b0, 32'h2000, 1'b1, 4'b1100, 32'h5678_5678};
        tbl[6]  = '{K_ACC, 32'h0000_2003, 32'h3000, 0, 32'hCAFE_BABE, 0, 1'b1, 0, 1'b0, 1'b1, 32'h3000, 1'b0, 4'hF, 0};
        tbl[7]  = '{K_ACC, 32'h0000_2003, 32'h3004, 0, 32'hCAFE_BABE, 4, 1'b1, 32'hCAFE_BABE, 1'b1, 1'b0, 32'h3004, 1'b0, 4'hF, 0};
        tbl[8]  = '{K_INV, 32'h0000_3003, 32'h4000, 0, 0, 0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 4'h0, 0};
        tbl[9]  = '{K_INV, 32'h0000_4023, 32'h4000, 0, 0, 0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 4'h0, 0};
        tbl[10] = '{K_ACC, 32'h0000_1003, 32'h2006, 0, 32'h8001_1234, 2, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 32'h2004, 1'b0, 4'b1100, 0};
        tbl[11] = '{K_ACC, 32'h0000_5003, 32'h2004, 0, 32'h8001_1234, 1, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 32'h2004, 1'b0, 4'b0011, 0};
        tbl[12] = '{K_ACC, 32'h0000_2023, 32'h2008, 32'h1122_3344, 0, 2, 1'b1, 32'h2008, 1'b0, 1'b0, 32'h2008, 1'b1, 4'hF, 32'h1122_3344};
        tbl[13] = '{K_MIS, 32'h0000_1023, 32'h2001, 0, 0, 0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 4'h0, 0};
        tbl[14] = '{K_PAS, 32'h0000_0013, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b0, 4'h0, 0};
        tbl[15] = '{K_INV, 32'h0000_3023, 32'h2003, 0, 0, 0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 4'h0, 0};

        // Reset with an aligned load and a pending ack on the inputs: reset must win.
        reset = 1'b0;
        iw_in = 32'h0000_2003; alu_in = 32'h1000; rs2_data_in = 32'h55; pc_in = 32'h40;
        wb_en_in = 1'b1; wb_reg_in = 5'd7; dmem_ack = 1'b1; dmem_rdata = 32'h1234;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        dmem_ack = 1'b0;

        for (int i = 0; i < 16; i++)
            run_op(tbl[i], 32'h100 + 32'(4 * i), 5'(i + 3));

        // Reset in the 2nd ACCESS cycle, then a late ack alongside a pass-through op.
        iw_in = 32'h0000_2003; alu_in = 32'h5000; pc_in = 32'h300; wb_en_in = 1'b1; wb_reg_in = 5'd4;
        @(negedge clk);
        check("rst_acc_c1", 64'({stall_out, dmem_req}), 64'(2'b11));
        @(negedge clk);
        check("rst_acc_c2", 64'({stall_out, dmem_req}), 64'(2'b11));
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("rst_acc");
        reset = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        iw_in = 32'h0000_0033; alu_in = 32'h77; pc_in = 32'h400; wb_en_in = 1'b1; wb_reg_in = 5'd9;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("late_ack_bus", 64'({stall_out, dmem_req, bus_err_out, misalign_out}), 64'(0));
        check("late_ack_pass", 64'({wb_data_out, wb_en_out, wb_reg_out}), 64'({32'h77, 1'b1, 5'd9}));

        for (int i = 0; i < 250; i++) begin
            int unsigned r, opc, f3;
            logic [31:0] iw, alu;
            r   = $urandom_range(0, 9);
            opc = (r < 4) ? 3 : (r < 8) ? 35 : ($urandom % 128);
            f3  = $urandom % 8;
            iw  = ($urandom & 32'hFFFF_8F80) | (f3 << 12) | opc;
            alu = $urandom;
            if ($urandom % 2 == 0) alu = alu & 32'hFFFF_FFFC;
            run_op(model(iw, alu, $urandom, $urandom, $urandom_range(0, TO), 1'($urandom % 2)),
                   $urandom, 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_stage.md
RV32I_MEM_STAGE -- requirements
Module: rv32i_mem_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, maximum ACCESS cycles to wait for dmem_ack before aborting (range 1..255).
REQ-002 SHALL have port: clk  in  1  system clock; single clock domain, all state updates on posedge clk.
REQ-003 SHALL have port: reset  in  1  synchronous, active-low reset; sampled only at posedge clk.
REQ-004 SHALL have ports from execute: alu_in in 32 (result or effective address); rs2_data_in in 32 (store data); iw_in in 32; pc_in in 32; wb_en_in in 1; wb_reg_in in 5.
REQ-005 SHALL have port: stall_out  out  1  high while the upstream stage holds its outputs.
REQ-006 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32 (word-aligned); dmem_be out 4; dmem_wdata out 32; dmem_rdata in 32; dmem_ack in 1.
REQ-007 SHALL have writeback ports, all registered: wb_data_out 32; iw_out 32; pc_out 32; wb_en_out 1; wb_reg_out 5; misalign_out 1; bus_err_out 1.

Function
REQ-008 SHALL decode iw_in[6:0]: 0000011 = load, 0100011 = store, anything else = pass-through; func3 = iw_in[14:12].
REQ-009 SHALL treat load func3 011/110/111 and store func3 011..111 as an invalid mem op: no access, output bubble (wb_en_out=0), no error flags.
REQ-010 SHALL flag misalignment: halfword ops with alu_in[0]=1; word ops with alu_in[1:0]!=00.
REQ-011 SHALL implement a two-state FSM: IDLE, ACCESS.
REQ-012 In IDLE, pass-through SHALL register wb_data_out=alu_in, wb_en_out=wb_en_in, iw/pc/wb_reg passed; latency 1 cycle; stay IDLE.
REQ-013 In IDLE, a misaligned load/store SHALL perform no access, register misalign_out=1 for one cycle with wb_en_out=0, iw/pc/wb_reg passed; stay IDLE.
REQ-014 In IDLE, an aligned valid load/store SHALL capture alu_in, rs2_data_in, iw_in, pc_in, wb_en_in, wb_reg_in into hold registers, register a bubble (wb_en_out=0), and enter ACCESS.
REQ-015 stall_out SHALL equal (state==ACCESS), combinationally from the state register.
REQ-016 In ACCESS, dmem_req SHALL be 1 and dmem_addr={hold_addr[31:2],2'b00}; dmem_we, dmem_be and dmem_wdata SHALL come from hold registers and be stable for the whole ACCESS period; all dmem outputs SHALL be 0 in IDLE.
REQ-017 Store lanes: SB be=0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=0011<<addr[1:0], wdata={2{rs2[15:0]}}; SW be=1111, wdata=rs2; loads have we=0 and be equal to the accessed lanes.
REQ-018 Load extraction: LB/LBU take byte addr[1:0] of dmem_rdata, sign-/zero-extended; LH/LHU take halfword addr[1], sign-/zero-extended; LW takes the full word.
REQ-019 On dmem_ack in ACCESS: load registers wb_data_out=extracted data and wb_en_out=hold wb_en; store registers wb_data_out=hold addr and wb_en_out=0; hold iw/pc/wb_reg registered; return to IDLE.
REQ-020 A timeout counter SHALL clear on ACCESS entry and count ACCESS cycles; if the TIMEOUT_CYCLES-th ACCESS cycle has no ack, SHALL return to IDLE, register bus_err_out=1 for one cycle and wb_en_out=0.
REQ-021 An ack on the TIMEOUT_CYCLES-th cycle SHALL complete normally (ack has priority over timeout).
REQ-022 dmem_ack in IDLE SHALL be ignored.
REQ-023 Outputs held in ACCESS without ack SHALL remain a bubble (wb_en_out=0, misalign_out=0, bus_err_out=0).
REQ-024 Minimum load/store latency SHALL be 2 cycles from presentation to wb outputs (accept edge + ack edge).

Reset
REQ-025 With reset=0 at posedge clk, SHALL set state=IDLE, counter=0, all hold registers=0 and all registered outputs=0.
REQ-026 Reset during ACCESS SHALL abandon the access; dmem_req=0 from the following cycle; any later ack SHALL be ignored.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-028 ADD-class iw (opcode 0110011), alu_in=0x0000_0005, wb_en_in=1, wb_reg_in=3 -> next cycle wb_data_out=5, wb_en_out=1, wb_reg_out=3, stall_out=0.
REQ-029 SB, alu_in=0x1003, rs2=0xAABB_CCDD; ack on 1st ACCESS cycle -> dmem_addr=0x1000, be=1000, wdata=0xDDDD_DDDD, we=1; stall_out high 1 cycle; wb_en_out=0.
REQ-030 LB, alu_in=0x2002, dmem_rdata=0x0080_0000, ack after 3 cycles -> wb_data_out=0xFFFF_FF80, wb_en_out=1; same with LBU -> 0x0000_0080.
REQ-031 LW alu_in=0x2001 -> no dmem_req, misalign_out=1 for one cycle, wb_en_out=0; SH alu_in=0x2002 -> be=1100, proceeds normally.
REQ-032 LW with no ack, TIMEOUT_CYCLES=4 -> dmem_req high exactly 4 cycles, then bus_err_out=1 for one cycle, stall_out drops; repeat with ack on 4th cycle -> normal completion, bus_err_out=0.
REQ-033 Reset=0 asserted in 2nd ACCESS cycle, ack asserted 1 cycle later -> dmem_req=0, all outputs 0, ack ignored, next pass-through instruction handled with 1-cycle latency.
